// File: rtl/mmio_display_ctrl.sv
// rtl/mmio_display_ctrl.sv - MMIO DATA/CTRL/COUNT window driving a scanned 7-segment display; MMIO_SIM_PRINT_EN traces counted DATA stores
module mmio_display_ctrl #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0064,
    parameter int          NUM_DIGITS = 8,
    parameter int          SCAN_DIV   = 1000,
    parameter int          RAM_ADR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     mem_adr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_be,
    input  logic                  wen,
    input  logic                  ren,
    output logic [31:0]           rdata,
    output logic                  rvalid,
    output logic [RAM_ADR_W-1:0]  ram_adr,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [ADDR_W-1:0] L_ADR_DATA  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] L_ADR_CTRL  = ADDR_W'(BASE_ADDR + 32'd4);
    localparam logic [ADDR_W-1:0] L_ADR_COUNT = ADDR_W'(BASE_ADDR + 32'd8);
    // Nibbles beyond the last physical digit must not defeat leading-zero blanking
    localparam logic [31:0] L_DISP_MASK = 32'hFFFF_FFFF >> (32 - 4 * NUM_DIGITS);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] v;
        v = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) v[8*k +: 8] = new_v[8*k +: 8];
        end
        return v;
    endfunction

    logic                  w_hit_data;
    logic                  w_hit_ctrl;
    logic                  w_hit_count;
    logic                  w_count_inc;
    logic [31:0]           w_data_mrg;
    logic [31:0]           w_ctrl_mrg;
    logic [31:0]           w_rd_mux;
    logic                  w_presc_tc;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [31:0]           w_disp_sh;
    logic [6:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    logic [31:0]           r_data;
    logic [31:0]           r_ctrl;
    logic [31:0]           r_count;
    logic [31:0]           r_rdata;
    logic                  r_rvalid;
    logic [PRE_W-1:0]      r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    assign w_hit_data  = (mem_adr == L_ADR_DATA);
    assign w_hit_ctrl  = (mem_adr == L_ADR_CTRL);
    assign w_hit_count = (mem_adr == L_ADR_COUNT);
    assign w_data_mrg  = merge_be(r_data, mem_wdata, mem_be);
    assign w_ctrl_mrg  = merge_be(r_ctrl, mem_wdata, mem_be);
    assign w_count_inc = wen && w_hit_data && (mem_be != 4'b0000);

    always_comb begin
        w_rd_mux = 32'h0;
        if (w_hit_data)       w_rd_mux = r_data;
        else if (w_hit_ctrl)  w_rd_mux = r_ctrl;
        else if (w_hit_count) w_rd_mux = r_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= 32'h0;
            r_ctrl  <= 32'h1;
            r_count <= 32'h0;
        end else begin
            if (wen && w_hit_data) r_data <= w_data_mrg;
            if (wen && w_hit_ctrl) r_ctrl <= w_ctrl_mrg;
            if (w_count_inc)       r_count <= r_count + 32'd1;
        end
    end

    // Loads see pre-store register values since the mux reads current state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= 32'h0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= ren && (w_hit_data || w_hit_ctrl || w_hit_count);
            r_rdata  <= ren ? w_rd_mux : 32'h0;
        end
    end

    assign w_presc_tc = (r_presc == PRE_W'(SCAN_DIV - 1));

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_presc_tc) begin
            w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    assign w_disp_sh = (r_data & L_DISP_MASK) >> {w_idx_nxt, 2'b00};

    always_comb begin
        w_an_nxt  = {NUM_DIGITS{1'b1}};
        w_seg_nxt = 7'h7F;
        if (r_ctrl[0]) begin
            w_an_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
            if (!(r_ctrl[1] && (w_idx_nxt != '0) && (w_disp_sh == 32'h0))) begin
                w_seg_nxt = hex7(w_disp_sh[3:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_an    <= ~NUM_DIGITS'(1);
            r_seg   <= 7'h40;
        end else begin
            r_presc <= w_presc_tc ? '0 : r_presc + 1'b1;
            r_idx   <= w_idx_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

`ifdef MMIO_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (!rst && w_count_inc) $display("Data %d", w_data_mrg);
    end
`endif

    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign ram_adr = mem_adr[RAM_ADR_W-1:0];
    assign seg     = r_seg;
    assign an      = r_an;
endmodule

// File: tb/tb_mmio_display_ctrl.sv
// tb/tb_mmio_display_ctrl.sv - randomized model-checked bench for mmio_display_ctrl
module tb_mmio_display_ctrl;
    localparam logic [31:0] BASE = 32'h8000_0064;
    localparam int ND = 8;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;
    logic [19:0] ram_adr;
    logic [6:0]  seg;
    logic [7:0]  an;

    always #5 clk = ~clk;

    mmio_display_ctrl #(
        .ADDR_W(32), .BASE_ADDR(BASE), .NUM_DIGITS(ND), .SCAN_DIV(SD), .RAM_ADR_W(20)
    ) dut (
        .clk(clk), .rst(rst), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .wen(wen), .ren(ren), .rdata(rdata), .rvalid(rvalid), .ram_adr(ram_adr),
        .seg(seg), .an(an)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [31:0] m_data, m_ctrl, m_count, m_rdata;
    logic        m_rvalid;
    logic        m_ok = 1'b0;
    int          m_k;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic mdisp(input int idx);
        logic [31:0] sh;
        if (!m_ctrl[0]) begin
            m_an  = 8'hFF;
            m_seg = 7'h7F;
        end else begin
            m_an = ~(8'(1) << idx);
            sh   = m_data >> (4 * idx);
            if (m_ctrl[1] && idx > 0 && sh == 0) m_seg = 7'h7F;
            else                                 m_seg = seg_tab[sh[3:0]];
        end
    endtask

    // Reference: digit slot follows elapsed cycles since reset; display lags registers by one edge
    always @(posedge clk) begin
        if (rst) begin
            m_data = 0; m_ctrl = 1; m_count = 0; m_k = 0;
            m_rvalid = 0; m_rdata = 0; m_ok = 1'b1;
            mdisp(0);
        end else if (m_ok) begin
            m_k++;
            mdisp((m_k / SD) % ND);
            m_rvalid = 0;
            m_rdata  = 0;
            if (ren) begin
                if (mem_adr == BASE)           begin m_rvalid = 1; m_rdata = m_data;  end
                else if (mem_adr == BASE + 4)  begin m_rvalid = 1; m_rdata = m_ctrl;  end
                else if (mem_adr == BASE + 8)  begin m_rvalid = 1; m_rdata = m_count; end
            end
            if (wen && mem_adr == BASE) begin
                m_data = mrg(m_data, mem_wdata, mem_be);
                if (mem_be != 0) m_count = m_count + 1;
            end
            if (wen && mem_adr == BASE + 4) m_ctrl = mrg(m_ctrl, mem_wdata, mem_be);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("rvalid", rvalid, m_rvalid);
            chk("rdata", rdata, m_rdata);
            chk("an", an, m_an);
            chk("seg", seg, m_seg);
            chk("ram_adr", ram_adr, mem_adr[19:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_adr = a; mem_wdata = d; mem_be = be; wen = 1;
        step();
        wen = 0; mem_be = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        mem_adr = a; ren = 1;
        step();
        ren = 0;
        chk({nm, "_valid"}, rvalid, 1);
        chk(nm, rdata, exp);
    endtask

    task automatic see_digit(input int i, input logic [6:0] exp, input string nm);
        logic [7:0] want_an;
        int n;
        want_an = ~(8'(1) << i);
        n = 0;
        step();
        while (an !== want_an && n < 64) begin
            step();
            n++;
        end
        chk({nm, "_an"}, an, want_an);
        chk(nm, seg, exp);
    endtask

    initial begin
        rst = 1; wen = 0; ren = 0; mem_adr = 0; mem_wdata = 0; mem_be = 0;
        step();
        step();
        rst = 0;
        chk("rst_an", an, 8'hFE);
        chk("rst_seg", seg, 7'h40);
        chk("rst_rvalid", rvalid, 0);
        repeat (4) step();
        chk("scan_step", an, 8'hFD);
        repeat (27) step();
        chk("scan_last", an, 8'h7F);
        step();
        chk("scan_wrap", an, 8'hFE);
        rd(BASE, 32'h0, "rst_data");
        rd(BASE + 4, 32'h1, "rst_ctrl");
        rd(BASE + 8, 32'h0, "rst_count");

        wr(BASE, 32'h1234_ABCD, 4'hF);
        wr(BASE, 32'hFFFF_FF00, 4'b0010);
        rd(BASE, 32'h1234_FFCD, "lane_merge");
        rd(BASE + 8, 32'd2, "count2");
        see_digit(1, 7'h46, "dig1_C");
        see_digit(2, 7'h0E, "dig2_F");

        wr(BASE + 4, 32'h3, 4'hF);
        wr(BASE, 32'h5, 4'hF);
        see_digit(0, 7'h12, "lzb_dig0");
        for (int i = 1; i < ND; i++) see_digit(i, 7'h7F, "lzb_blank");
        wr(BASE + 4, 32'h1, 4'hF);
        for (int i = 1; i < ND; i++) see_digit(i, 7'h40, "nolzb_zero");

        wr(BASE + 4, 32'h0, 4'hF);
        step();
        for (int i = 0; i < ND * SD; i++) begin
            chk("off_an", an, 8'hFF);
            chk("off_seg", seg, 7'h7F);
            step();
        end
        wr(BASE + 4, 32'h1, 4'hF);
        step();

        wr(BASE, 32'h7, 4'hF);
        mem_adr = BASE; mem_wdata = 32'h9; mem_be = 4'hF; wen = 1; ren = 1;
        step();
        wen = 0; ren = 0; mem_be = 0;
        chk("rbw_valid", rvalid, 1);
        chk("rbw_old", rdata, 32'h7);
        rd(BASE, 32'h9, "rbw_new");
        mem_adr = BASE + 12; ren = 1;
        step();
        ren = 0;
        chk("miss_valid", rvalid, 0);
        chk("miss_data", rdata, 0);
        wr(BASE + 8, 32'h123, 4'hF);
        rd(BASE + 8, 32'd5, "count_ro");

        force dut.r_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_count;
        wr(BASE, 32'h1, 4'hF);
        rd(BASE + 8, 32'h0, "count_wrap");

        mem_adr = BASE; ren = 1;
        step();
        chk("pre_rst_valid", rvalid, 1);
        rst = 1;
        step();
        rst = 0; ren = 0;
        chk("rst_kill_valid", rvalid, 0);
        chk("rst_kill_data", rdata, 0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            wen = $urandom_range(0, 1);
            ren = $urandom_range(0, 1);
            mem_be = 4'($urandom);
            mem_wdata = $urandom;
            case ($urandom_range(0, 4))
                0: mem_adr = BASE;
                1: mem_adr = BASE + 4;
                2: mem_adr = BASE + 8;
                3: mem_adr = BASE + 12;
                default: mem_adr = $urandom;
            endcase
            step();
        end
        rst = 0; wen = 0; ren = 0; mem_be = 0;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
